argmax_stream: RTL and testbench

Sequential argmax stage at the output of the neural network's final layer. Consumes the output-layer scores as a serial valid/ready stream, one score per beat. Tracks the running maximum and its index, then presents the winning class (recognised digit) with a one-cycle done pulse. Replaces a parallel compare tree when output scores arrive serially from a time-multiplexed output layer.

---
 rtl/nn_pkg.sv | 12 +
 rtl/argmax_select.sv | 23 ++
 rtl/argmax_stream.sv | 101 ++++++++++
 tb/tb_argmax_stream.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Constants shared by the output layer, the argmax stage and the result logic.
// Also holds the argmax FSM state encoding.
package nn_pkg;

    localparam int NUM_CLASSES      = 10;
    localparam int SCORE_RESOLUTION = 8;
    localparam int CLASS_INDEX_SIZE = 4;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

endpackage

// File: rtl/argmax_select.sv
// One step of the running argmax: keep the current winner unless the new score
// is strictly greater, so ties resolve to the earliest index.
module argmax_select #(
    parameter int resolution = 8,
    parameter int index_size = 4
) (
    input  logic                  first,
    input  logic [resolution-1:0] cur_max,
    input  logic [index_size-1:0] cur_idx,
    input  logic [resolution-1:0] new_val,
    input  logic [index_size-1:0] new_idx,
    output logic [resolution-1:0] nxt_max,
    output logic [index_size-1:0] nxt_idx
);

    logic take_new;

    // The first beat of a frame always wins, whatever was left in the registers.
    assign take_new = first || (new_val > cur_max);
    assign nxt_max  = take_new ? new_val : cur_max;
    assign nxt_idx  = take_new ? new_idx : cur_idx;

endmodule

// File: rtl/argmax_stream.sv
// Serial argmax over one frame of output-layer scores; reports the winning class
// with a one-cycle done pulse after the final beat.
module argmax_stream
    import nn_pkg::*;
#(
    parameter int resolution  = SCORE_RESOLUTION,
    parameter int index_size  = CLASS_INDEX_SIZE,
    parameter int num_classes = NUM_CLASSES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [resolution-1:0] in_data,
    input  logic                  in_last,
    output logic                  busy,
    output logic                  done,
    output logic [resolution-1:0] max_val,
    output logic [index_size-1:0] max_idx,
    output logic                  err,
    output logic [0:0]            fsm_state
);

    localparam logic [index_size-1:0] LAST_IDX = index_size'(num_classes - 1);

    logic [0:0]            state;
    logic [index_size-1:0] cnt;
    logic [resolution-1:0] run_max;
    logic [index_size-1:0] run_idx;
    logic [resolution-1:0] sel_max;
    logic [index_size-1:0] sel_idx;
    logic                  accept;
    logic                  count_full;
    logic                  frame_end;

    // Handshake: a beat transfers on a cycle where in_valid and in_ready are both
    // high; in_ready is high exactly while collecting, and in_data/in_last are
    // only looked at on a transfer.
    assign in_ready   = (state == ST_COLLECT);
    assign busy       = (state == ST_COLLECT);
    assign fsm_state  = state;
    assign accept     = in_valid && in_ready;
    assign count_full = (cnt == LAST_IDX);
    assign frame_end  = accept && (count_full || in_last);

    argmax_select #(
        .resolution (resolution),
        .index_size (index_size)
    ) u_select (
        .first   (cnt == '0),
        .cur_max (run_max),
        .cur_idx (run_idx),
        .new_val (in_data),
        .new_idx (cnt),
        .nxt_max (sel_max),
        .nxt_idx (sel_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            run_max <= '0;
            run_idx <= '0;
            done    <= 1'b0;
            max_val <= '0;
            max_idx <= '0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_COLLECT;
                        cnt     <= '0;
                        run_max <= '0;
                        run_idx <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (accept) begin
                        run_max <= sel_max;
                        run_idx <= sel_idx;
                        cnt     <= cnt + index_size'(1);
                    end
                    if (frame_end) begin
                        state   <= ST_IDLE;
                        max_val <= sel_max;
                        max_idx <= sel_idx;
                        // Flag frames whose in_last marker disagrees with the beat count.
                        err     <= (in_last != count_full);
                        done    <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_stream.sv
// Directed bench for argmax_stream: hand-computed frame results checked with
// immediate assertions around each done pulse.
module tb_argmax_stream;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       busy;
    logic       done;
    logic [7:0] max_val;
    logic [3:0] max_idx;
    logic       err;
    logic [0:0] fsm_state;

    int vectors     = 0;
    int miscompares = 0;

    // Expected frame results, packed as {err, idx, val}.
    logic [12:0] exp_q[$];
    logic [7:0]  frm[10];
    logic [7:0]  held_val;
    logic [3:0]  held_idx;
    logic        held_err;

    always #5 clk = ~clk;

    argmax_stream dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .busy      (busy),
        .done      (done),
        .max_val   (max_val),
        .max_idx   (max_idx),
        .err       (err),
        .fsm_state (fsm_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [7:0] v, input logic [3:0] idx, input logic e);
        exp_q.push_back({e, idx, v});
    endtask

    // last_at < 0 means no in_last; gap inserts idle cycles between beats.
    task automatic run_frame(input int n, input int last_at, input int gap,
                             input bit hold_start, input bit skip_start, input bit chain_next);
        logic [12:0] e;
        if (!skip_start) begin
            start = 1'b1;
            tick();
        end
        start = hold_start;
        chk("busy_collect", busy, 1);
        chk("ready_collect", in_ready, 1);
        chk("state_collect", fsm_state, 1);
        chk("hold_val", max_val, held_val);
        chk("hold_idx", max_idx, held_idx);
        chk("hold_err", err, held_err);
        for (int i = 0; i < n; i++) begin
            start    = hold_start && (i < n - 1);
            in_valid = 1'b1;
            in_data  = frm[i];
            in_last  = (i == last_at);
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_data  = 8'd0;
            if (i < n - 1) begin
                chk("no_early_done", done, 0);
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk("gap_busy", busy, 1);
                    chk("gap_done", done, 0);
                end
            end
        end
        start = 1'b0;
        e = exp_q.pop_front();
        chk("done_pulse", done, 1);
        chk("max_val", max_val, e[7:0]);
        chk("max_idx", max_idx, e[11:8]);
        chk("err", err, e[12]);
        chk("idle_busy", busy, 0);
        chk("idle_ready", in_ready, 0);
        held_val = e[7:0];
        held_idx = e[11:8];
        held_err = e[12];
        if (chain_next) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("done_one_cycle", done, 0);
            chk("chain_busy", busy, 1);
        end else begin
            tick();
            chk("done_one_cycle", done, 0);
            chk("stay_idle", busy, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        in_last  = 1'b0;
        held_val = 8'd0;
        held_idx = 4'd0;
        held_err = 1'b0;
        repeat (2) tick();
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_val", max_val, 0);
        chk("rst_idx", max_idx, 0);
        chk("rst_err", err, 0);
        chk("rst_state", fsm_state, 0);
        reset = 1'b0;
        tick();

        // in_valid while idle must be ignored.
        in_valid = 1'b1;
        in_data  = 8'd77;
        in_last  = 1'b1;
        repeat (3) begin
            tick();
            chk("idle_ready", in_ready, 0);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'd0;
        tick();

        frm = '{8'd3, 8'd9, 8'd1, 8'd200, 8'd5, 8'd7, 8'd0, 8'd2, 8'd4, 8'd6};
        push_exp(8'd200, 4'd3, 1'b0);
        run_frame(10, 9, 0, 1'b0, 1'b0, 1'b0);

        // Ties keep the earliest index; start lands in the done cycle.
        frm = '{8'd50, 8'd10, 8'd50, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd50};
        push_exp(8'd50, 4'd0, 1'b0);
        run_frame(10, 9, 0, 1'b0, 1'b0, 1'b1);

        frm = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        push_exp(8'd0, 4'd0, 1'b0);
        run_frame(10, 9, 0, 1'b0, 1'b1, 1'b0);

        frm = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd99, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        push_exp(8'd99, 4'd4, 1'b1);
        run_frame(5, 4, 0, 1'b0, 1'b0, 1'b0);

        frm = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd255};
        push_exp(8'd255, 4'd9, 1'b0);
        run_frame(10, 9, 2, 1'b0, 1'b0, 1'b0);

        frm = '{8'd3, 8'd9, 8'd1, 8'd200, 8'd5, 8'd7, 8'd0, 8'd2, 8'd4, 8'd6};
        push_exp(8'd200, 4'd3, 1'b1);
        run_frame(10, -1, 0, 1'b0, 1'b0, 1'b0);

        // start held high through collection must not restart the frame.
        frm = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd100, 8'd9, 8'd8, 8'd7, 8'd6};
        push_exp(8'd100, 4'd5, 1'b0);
        run_frame(10, 9, 0, 1'b1, 1'b0, 1'b0);

        // Reset after beat 5 discards the partial frame.
        frm = '{8'd1, 8'd2, 8'd3, 8'd250, 8'd5, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = frm[i];
            tick();
        end
        in_valid = 1'b0;
        in_data  = 8'd0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_val", max_val, 0);
        chk("mid_rst_idx", max_idx, 0);
        chk("mid_rst_err", err, 0);
        held_val = 8'd0;
        held_idx = 4'd0;
        held_err = 1'b0;
        repeat (3) begin
            tick();
            chk("mid_rst_no_done", done, 0);
        end

        frm = '{8'd3, 8'd9, 8'd1, 8'd200, 8'd5, 8'd7, 8'd0, 8'd2, 8'd4, 8'd6};
        push_exp(8'd200, 4'd3, 1'b0);
        run_frame(10, 9, 0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
